mcycle_unit: RTL and testbench

- Iterative multiply/divide unit that sits directly downstream of the control unit.
- Consumes MS (start) and MCycleOp from decode, and Rn/Rm operand values from the register file.
- Produces a 2×WIDTH result that is written back once the datapath stall ends.
- Busy stalls the pipeline/PC while an operation is in flight.

---
 rtl/mcycle_unit.sv | 109 ++++++++++
 tb/tb_mcycle_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with a 2xWIDTH result.
// Optional macro MCYCLE_EARLY_TERM_EN: MUL finishes once the remaining multiplier bits are zero.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, COMPUTING} state_t;

  state_t             state;
  logic               op;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] mcand;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic               last;

  // MUL: {hi,lo} is the running product. DIV: hi is the partial remainder, lo the dividend/quotient shifter.
  always_comb begin
    acc_next = {hi, lo};
    rem_sh   = {hi, lo[WIDTH-1]};
    diff     = rem_sh - {1'b0, mplr};
    hi_next  = hi;
    lo_next  = lo;
    if (!op) begin
      if (mplr[0]) acc_next = {hi, lo} + mcand;
      hi_next = acc_next[2*WIDTH-1:WIDTH];
      lo_next = acc_next[WIDTH-1:0];
    end else if (!diff[WIDTH]) begin
      hi_next = diff[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = rem_sh[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b0};
    end
    last = (count == CW'(WIDTH - 1));
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op && ((mplr >> 1) == '0)) last = 1'b1;
`endif
  end

  assign Busy = ((state == IDLE) && Start) || (state == COMPUTING);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      op      <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      mplr    <= '0;
      mcand   <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= COMPUTING;
            op    <= MCycleOp;
            count <= '0;
            hi    <= '0;
            lo    <= MCycleOp ? Operand1 : '0;
            mplr  <= Operand2;
            mcand <= {{WIDTH{1'b0}}, Operand1};
          end
        end
        COMPUTING: begin
          hi    <= hi_next;
          lo    <= lo_next;
          count <= count + CW'(1);
          if (!op) begin
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
          end
          if (last) begin
            state   <= IDLE;
            Result1 <= lo_next;
            Result2 <= hi_next;
            Done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: reference model computes results and completion cycle arithmetically.
module tb_mcycle_unit;
  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         Start = 1'b0;
  logic         MCycleOp = 1'b0;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           model_end = 0;
  bit           armed = 1'b0;
  logic [W-1:0] held_r1 = '0;
  logic [W-1:0] held_r2 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int iterations(input bit op, input logic [W-1:0] b);
    int n;
    n = W;
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op) begin
      n = 1;
      for (int i = 0; i < int'(W); i++) if (b[i]) n = i + 1;
    end
`endif
    return n;
  endfunction

  function automatic exp_t reference(input bit op, input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    logic [2*W-1:0] p;
    if (!op) begin
      p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.r1 = p[W-1:0];
      e.r2 = p[2*W-1:W];
    end else if (b == '0) begin
      e.r1 = '1;
      e.r2 = a;
    end else begin
      e.r1 = a / b;
      e.r2 = a % b;
    end
    e.due = due;
    return e;
  endfunction

  // Cycle counter and the model's view of a synchronous reset.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (RESET) begin
      armed   = 1'b1;
      held_r1 = '0;
      held_r2 = '0;
      sb.delete();
    end
  end

  // Monitor: checks completions against the scoreboard and result hold between completions.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (armed) begin
        if (Done === 1'b1) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 64'(Done), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.due));
            chk("result1", 64'(Result1), 64'(e.r1));
            chk("result2", 64'(Result2), 64'(e.r2));
            held_r1 = e.r1;
            held_r2 = e.r2;
          end
        end else begin
          chk("done_low", 64'(Done), 64'd0);
          chk("hold_result1", 64'(Result1), 64'(held_r1));
          chk("hold_result2", 64'(Result2), 64'(held_r2));
          if (sb.size() != 0 && cyc > sb[0].due) begin
            chk("done_missing", 64'(cyc), 64'(sb[0].due));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // One cycle of stimulus; the model decides whether a Start is accepted.
  task automatic step(input bit st, input bit op, input logic [W-1:0] a, input logic [W-1:0] b, input bit rst);
    int n;
    @(negedge CLK);
    Start    = st;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    RESET    = rst;
    #1;
    if (!rst) chk("busy", 64'(Busy), 64'((cyc < model_end) || (st && cyc >= model_end)));
    if (rst) begin
      model_end = cyc + 1;
    end else if (st && cyc >= model_end) begin
      n         = iterations(op, b);
      model_end = cyc + n + 1;
      sb.push_back(reference(op, a, b, model_end));
    end
  endtask

  task automatic idle(input bit noise);
    step(noise && ($urandom_range(0, 7) == 0), 1'($urandom), $urandom, $urandom, 1'b0);
  endtask

  // Idle until the cycle before `target`, so the next step lands on `target`.
  task automatic wait_before(input int target, input bit noise);
    int guard;
    guard = 0;
    while (cyc + 1 < target && guard < 200) begin
      idle(noise);
      guard++;
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           op;
    int           k;

    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
    idle(1'b0);

    step(1'b1, 1'b0, 32'd7, 32'd6, 1'b0);
    wait_before(model_end + 1, 1'b0);

    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0);
    wait_before(model_end + 1, 1'b0);

    step(1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
    wait_before(model_end + 1, 1'b0);
    step(1'b1, 1'b1, 32'h1234, 32'd0, 1'b0);
    wait_before(model_end + 1, 1'b0);

    step(1'b1, 1'b1, 32'd50, 32'd5, 1'b0);
    k = cyc;
    wait_before(k + 10, 1'b0);
    step(1'b1, 1'b0, 32'd3, 32'd3, 1'b0);
    wait_before(model_end, 1'b0);
    step(1'b1, 1'b0, 32'd3, 32'd3, 1'b0);
    wait_before(model_end + 1, 1'b0);

    step(1'b1, 1'b0, 32'hFFFF, 32'hFFFF, 1'b0);
    k = cyc;
    wait_before(k + 10, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    idle(1'b0);
    step(1'b1, 1'b0, 32'd2, 32'd3, 1'b0);
    wait_before(model_end + 1, 1'b0);

    step(1'b1, 1'b1, 32'd9, 32'd2, 1'b1);
    idle(1'b0);

    step(1'b1, 1'b0, 32'd5, 32'd3, 1'b0);
    wait_before(model_end + 1, 1'b0);
    step(1'b1, 1'b0, 32'd9, 32'd0, 1'b0);
    wait_before(model_end + 1, 1'b0);
    step(1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
    wait_before(model_end + 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(0, 15));
        2:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) wait_before(model_end, 1'b1);
      else wait_before(model_end + 1 + int'($urandom_range(0, 2)), 1'b1);
      step(1'b1, op, a, b, 1'b0);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(1, 20)) idle(1'b0);
        step(1'($urandom), 1'b0, '0, '0, 1'b1);
      end
    end

    wait_before(model_end + 3, 1'b0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
